// File: rtl/read_out_pkg.sv
// Shared definitions for the output-SRAM read path: bank encodings,
// controller state type and the default row address width.
package read_out_pkg;

    localparam int ADDR_WIDTH = 6;
    localparam int FIFO_DEPTH = 2;

    localparam logic [1:0] BANK_A = 2'd0;
    localparam logic [1:0] BANK_B = 2'd1;
    localparam logic [1:0] BANK_C = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Encoding 3 does not name a bank.
    function automatic logic bank_legal(input logic [1:0] sel);
        return sel != 2'd3;
    endfunction

endpackage

// File: rtl/read_skid_fifo.sv
// Two-entry FIFO holding lane-reversed rows between SRAM capture and the
// output handshake. Head entry is presented directly on o_data.
module read_skid_fifo
    import read_out_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_count,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_count;

    logic w_full;
    logic w_do_push;
    logic w_do_pop;

    assign w_full    = (r_count == 2'(FIFO_DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !o_empty;
    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign w_do_push = i_push && (!w_full || w_do_pop);

    assign o_data  = r_mem[r_rptr];
    assign o_count = r_count;

    // Storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= ~r_wptr;
            end
            if (w_do_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/read_out.sv
// Output-SRAM reader: drains a run of rows from bank a, b or c, undoes the
// writer's lane reversal and streams the rows over a valid/ready handshake.
module read_out
    import read_out_pkg::*;
#(
    parameter int ARRAY_SIZE        = 32,
    parameter int OUTPUT_DATA_WIDTH = 16,
    parameter int ADDR_WIDTH        = read_out_pkg::ADDR_WIDTH
) (
    input  logic                                      clk,
    input  logic                                      srst,
    input  logic                                      start,
    input  logic [1:0]                                bank_sel,
    input  logic [ADDR_WIDTH-1:0]                     base_addr,
    input  logic [ADDR_WIDTH:0]                       num_rows,

    output logic                                      sram_read_enable_a0,
    output logic [ADDR_WIDTH-1:0]                     sram_raddr_a,
    input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0]   sram_rdata_a,
    output logic                                      sram_read_enable_b0,
    output logic [ADDR_WIDTH-1:0]                     sram_raddr_b,
    input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0]   sram_rdata_b,
    output logic                                      sram_read_enable_c0,
    output logic [ADDR_WIDTH-1:0]                     sram_raddr_c,
    input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0]   sram_rdata_c,

    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0]   out_data,
    output logic                                      out_last,
    output logic                                      busy,
    output logic                                      done
);

    localparam int DW = ARRAY_SIZE * OUTPUT_DATA_WIDTH;
    localparam int CW = ADDR_WIDTH + 1;

    state_t                r_state;
    logic [1:0]            r_bank;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [CW-1:0]         r_issue_cnt;
    logic [CW-1:0]         r_num_rows;
    logic [CW-1:0]         r_out_cnt;
    logic                  r_inflight;
    logic                  r_busy;
    logic                  r_done;

    logic                  r_ren_a;
    logic                  r_ren_b;
    logic                  r_ren_c;
    logic [ADDR_WIDTH-1:0] r_raddr_a;
    logic [ADDR_WIDTH-1:0] r_raddr_b;
    logic [ADDR_WIDTH-1:0] r_raddr_c;

    logic [DW-1:0]         w_rdata_sel;
    logic [DW-1:0]         w_rev;
    logic [DW-1:0]         w_head;
    logic [1:0]            w_fifo_count;
    logic                  w_fifo_empty;
    logic                  w_pop;
    logic [2:0]            w_occupancy;
    logic                  w_issue;
    logic [CW-1:0]         w_last_idx;
    logic                  w_last_row;
    logic                  w_accept;

    assign sram_read_enable_a0 = r_ren_a;
    assign sram_read_enable_b0 = r_ren_b;
    assign sram_read_enable_c0 = r_ren_c;
    assign sram_raddr_a        = r_raddr_a;
    assign sram_raddr_b        = r_raddr_b;
    assign sram_raddr_c        = r_raddr_c;

    assign out_valid = !w_fifo_empty;
    assign out_data  = w_head;
    assign busy      = r_busy;
    assign done      = r_done;

    assign w_pop      = out_valid && out_ready;
    assign w_last_idx = r_num_rows - CW'(1);
    assign w_last_row = (r_out_cnt == w_last_idx);
    assign out_last   = out_valid && w_last_row;
    assign w_accept   = start && bank_legal(bank_sel) && (num_rows != '0);

    // Rows already buffered or captured next edge, net of the row leaving
    // this cycle. Counting the departing row lets a new read go out every
    // cycle under a steady ready without the FIFO ever exceeding two entries.
    assign w_occupancy = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue     = (r_state == READ) && (r_issue_cnt != '0) && (w_occupancy < 3'd2);

    // Route the latched bank's read data to the capture path.
    always_comb begin
        w_rdata_sel = '0;
        case (r_bank)
            BANK_A:  w_rdata_sel = sram_rdata_a;
            BANK_B:  w_rdata_sel = sram_rdata_b;
            BANK_C:  w_rdata_sel = sram_rdata_c;
            default: w_rdata_sel = '0;
        endcase
    end

    // SRAM lane MAX_INDEX-i becomes output lane i.
    always_comb begin
        w_rev = '0;
        for (int unsigned i = 0; i < ARRAY_SIZE; i++) begin
            w_rev[i*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH] =
                w_rdata_sel[(ARRAY_SIZE-1-i)*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH];
        end
    end

    read_skid_fifo #(
        .WIDTH (DW)
    ) u_fifo (
        .clk     (clk),
        .srst    (srst),
        .i_push  (r_inflight),
        .i_pop   (w_pop),
        .i_data  (w_rev),
        .o_data  (w_head),
        .o_count (w_fifo_count),
        .o_empty (w_fifo_empty)
    );

    // Request controller: accepts a request, issues reads against the
    // credit limit, tracks delivered rows and signals completion.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_state     <= IDLE;
            r_bank      <= BANK_A;
            r_addr      <= '0;
            r_issue_cnt <= '0;
            r_num_rows  <= '0;
            r_out_cnt   <= '0;
            r_inflight  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_ren_a     <= 1'b1;
            r_ren_b     <= 1'b1;
            r_ren_c     <= 1'b1;
            r_raddr_a   <= '0;
            r_raddr_b   <= '0;
            r_raddr_c   <= '0;
        end else begin
            r_done     <= 1'b0;
            r_inflight <= w_issue;
            r_ren_a    <= 1'b1;
            r_ren_b    <= 1'b1;
            r_ren_c    <= 1'b1;
            if (w_pop) begin
                r_out_cnt <= r_out_cnt + CW'(1);
            end

            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_bank      <= bank_sel;
                        r_addr      <= base_addr;
                        r_issue_cnt <= num_rows;
                        r_num_rows  <= num_rows;
                        r_out_cnt   <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= READ;
                    end
                end

                READ: begin
                    if (w_issue) begin
                        case (r_bank)
                            BANK_A: begin
                                r_ren_a   <= 1'b0;
                                r_raddr_a <= r_addr;
                            end
                            BANK_B: begin
                                r_ren_b   <= 1'b0;
                                r_raddr_b <= r_addr;
                            end
                            BANK_C: begin
                                r_ren_c   <= 1'b0;
                                r_raddr_c <= r_addr;
                            end
                            default: begin
                                r_ren_a <= 1'b1;
                            end
                        endcase
                        r_addr      <= r_addr + ADDR_WIDTH'(1);
                        r_issue_cnt <= r_issue_cnt - CW'(1);
                        if (r_issue_cnt == CW'(1)) begin
                            r_state <= DRAIN;
                        end
                    end
                end

                DRAIN: begin
                    if (w_pop && w_last_row) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_read_out.sv
// Directed bench for read_out with a behavioural three-bank SRAM whose
// read data settles before the clock edge that closes the strobe cycle.
`timescale 1ns/1ps
module tb_read_out;

    localparam int AS = 32;
    localparam int W  = 16;
    localparam int AW = 6;
    localparam int DW = AS * W;

    logic          clk = 1'b0;
    logic          srst;
    logic          start;
    logic [1:0]    bank_sel;
    logic [AW-1:0] base_addr;
    logic [AW:0]   num_rows;
    logic          ren_a, ren_b, ren_c;
    logic [AW-1:0] raddr_a, raddr_b, raddr_c;
    logic [DW-1:0] rdata_a, rdata_b, rdata_c;
    logic          out_valid, out_ready, out_last, busy, done;
    logic [DW-1:0] out_data;

    int n_assert = 0;
    int n_fail   = 0;
    int fs, fv, dc;

    always #5 clk = ~clk;

    read_out #(
        .ARRAY_SIZE        (AS),
        .OUTPUT_DATA_WIDTH (W),
        .ADDR_WIDTH        (AW)
    ) dut (
        .clk                 (clk),
        .srst                (srst),
        .start               (start),
        .bank_sel            (bank_sel),
        .base_addr           (base_addr),
        .num_rows            (num_rows),
        .sram_read_enable_a0 (ren_a),
        .sram_raddr_a        (raddr_a),
        .sram_rdata_a        (rdata_a),
        .sram_read_enable_b0 (ren_b),
        .sram_raddr_b        (raddr_b),
        .sram_rdata_b        (rdata_b),
        .sram_read_enable_c0 (ren_c),
        .sram_raddr_c        (raddr_c),
        .sram_rdata_c        (rdata_c),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_data            (out_data),
        .out_last            (out_last),
        .busy                (busy),
        .done                (done)
    );

    // Lane j of the word stored at (bank, addr) in SRAM.
    function automatic logic [W-1:0] pat(input logic [1:0] bank, input logic [5:0] addr, input int lane);
        logic [4:0] l;
        l = lane[4:0];
        return {bank, addr, l, 3'b011};
    endfunction

    function automatic logic [DW-1:0] sram_word(input logic [1:0] bank, input logic [5:0] addr);
        logic [DW-1:0] w;
        for (int j = 0; j < AS; j++) w[j*W +: W] = pat(bank, addr, j);
        return w;
    endfunction

    // Output lane i carries SRAM lane 31-i.
    function automatic logic [DW-1:0] exp_row(input logic [1:0] bank, input logic [5:0] addr);
        logic [DW-1:0] w;
        for (int i = 0; i < AS; i++) w[i*W +: W] = pat(bank, addr, AS - 1 - i);
        return w;
    endfunction

    function automatic logic [DW-1:0] junk_word();
        logic [DW-1:0] w;
        for (int k = 0; k < DW / 32; k++) w[k*32 +: 32] = $urandom();
        return w;
    endfunction

    // Read data is meaningful only while the strobe is low; otherwise noise.
    always @(negedge clk) begin
        rdata_a <= !ren_a ? sram_word(2'd0, raddr_a) : junk_word();
        rdata_b <= !ren_b ? sram_word(2'd1, raddr_b) : junk_word();
        rdata_c <= !ren_c ? sram_word(2'd2, raddr_c) : junk_word();
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_strobes"}, {ren_a, ren_b, ren_c}, 3'b111);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_valid"}, out_valid, 1'b0);
    endtask

    // One request; tracks addresses, data, stalls, last and done timing.
    task automatic run_req(input logic [1:0] bank, input logic [5:0] base, input logic [6:0] n,
                           input logic [3:0] rdy_pat, input int inject_c, input int abort_rx,
                           output int first_strobe_c, output int first_valid_c, output int done_c);
        int c, issued, rx, last_hs_c;
        bit fin, aborted, stalled, rdy;
        logic sel_ren;
        logic [2:0] others;
        logic [5:0] sel_raddr, a;
        logic [DW-1:0] held;
        c = 0; issued = 0; rx = 0; last_hs_c = -10;
        fin = 0; aborted = 0; stalled = 0; held = '0;
        first_strobe_c = -1; first_valid_c = -1; done_c = -1;
        bank_sel = bank; base_addr = base; num_rows = n; start = 1'b1; out_ready = 1'b0;
        tick();
        start = 1'b0; bank_sel = 2'd3; base_addr = 6'd0; num_rows = 7'd0;
        chk("busy_accept", busy, 1'b1);
        while (!fin && c < 4 * int'(n) + 20) begin
            tick();
            c++;
            if (c == inject_c) begin
                start = 1'b1; bank_sel = (bank == 2'd0) ? 2'd1 : 2'd0; base_addr = 6'd33; num_rows = 7'd5;
            end else begin
                start = 1'b0; bank_sel = 2'd3; base_addr = 6'd0; num_rows = 7'd0;
            end
            case (bank)
                2'd0: begin sel_ren = ren_a; sel_raddr = raddr_a; others = {ren_b, ren_c, 1'b1}; end
                2'd1: begin sel_ren = ren_b; sel_raddr = raddr_b; others = {ren_a, ren_c, 1'b1}; end
                default: begin sel_ren = ren_c; sel_raddr = raddr_c; others = {ren_a, ren_b, 1'b1}; end
            endcase
            chk("unselected_strobes", others, 3'b111);
            if (!sel_ren) begin
                if (first_strobe_c < 0) first_strobe_c = c;
                a = base + issued[5:0];
                chk("raddr", sel_raddr, a);
                issued++;
                chk("outstanding_le2", (issued - rx) <= 2, 1'b1);
            end
            if (stalled) begin
                chk("hold_valid", out_valid, 1'b1);
                chk("hold_data", out_data, held);
            end
            if (abort_rx > 0 && rx == abort_rx) begin
                srst = 1'b1; out_ready = 1'b0; aborted = 1; fin = 1;
            end else if (done) begin
                chk("done_timing", c, last_hs_c + 1);
                chk("rows_delivered", rx, n);
                chk("issued_total", issued, n);
                chk("busy_clear", busy, 1'b0);
                done_c = c; fin = 1;
            end else begin
                chk("busy_hold", busy, 1'b1);
                rdy = rdy_pat[c % 4];
                out_ready = rdy;
                if (out_valid && first_valid_c < 0) first_valid_c = c;
                if (out_valid) begin
                    a = base + rx[5:0];
                    chk("row_data", out_data, exp_row(bank, a));
                    chk("out_last", out_last, rx == int'(n) - 1);
                end else begin
                    chk("last_idle", out_last, 1'b0);
                end
                stalled = out_valid && !rdy;
                held = out_data;
                if (out_valid && rdy) begin rx++; last_hs_c = c; end
            end
        end
        chk("finished_in_budget", fin, 1'b1);
        out_ready = 1'b0;
        tick();
        if (aborted) begin
            srst = 1'b0;
            chk_idle("abort");
            chk("abort_last", out_last, 1'b0);
            chk("abort_data", out_data, '0);
            for (int k = 0; k < 4; k++) begin
                tick();
                chk_idle("abort_quiet");
            end
        end else begin
            chk_idle("after_done");
        end
    endtask

    initial begin
        srst = 1'b1; start = 1'b0; bank_sel = 2'd0; base_addr = '0; num_rows = '0; out_ready = 1'b0;
        tick();
        tick();
        chk("rst_strobes", {ren_a, ren_b, ren_c}, 3'b111);
        chk("rst_raddr", {raddr_a, raddr_b, raddr_c}, 18'd0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_data", out_data, '0);
        chk("rst_last", out_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);

        // Reset beats a simultaneous start.
        start = 1'b1; bank_sel = 2'd0; num_rows = 7'd4;
        tick();
        start = 1'b0; srst = 1'b0;
        chk("rst_vs_start_busy", busy, 1'b0);
        tick();
        chk_idle("rst_vs_start");

        // Bank a, base 0, 4 rows, ready held high.
        run_req(2'd0, 6'd0, 7'd4, 4'b1111, 0, 0, fs, fv, dc);
        chk("t1_first_strobe", fs, 1);
        chk("t1_first_valid", fv, 2);
        chk("t1_done_cycle", dc, 6);

        // Bank c, base 62, 3 rows: address wraps 63 -> 0.
        run_req(2'd2, 6'd62, 7'd3, 4'b1111, 0, 0, fs, fv, dc);
        chk("t2_done_cycle", dc, 5);

        // Bank b, 8 rows, ready pattern 1,0,0,1.
        run_req(2'd1, 6'd20, 7'd8, 4'b1001, 0, 0, fs, fv, dc);

        // Start during busy with another bank/base is ignored.
        run_req(2'd2, 6'd40, 7'd8, 4'b1111, 3, 0, fs, fv, dc);
        chk("t4_done_cycle", dc, 10);

        // Illegal bank and zero-length requests are dropped.
        start = 1'b1; bank_sel = 2'd3; base_addr = 6'd7; num_rows = 7'd4;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin chk_idle("bank3"); tick(); end
        start = 1'b1; bank_sel = 2'd1; base_addr = 6'd7; num_rows = 7'd0;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin chk_idle("rows0"); tick(); end

        // Reset after two of six rows abandons the request.
        run_req(2'd0, 6'd12, 7'd6, 4'b1111, 0, 2, fs, fv, dc);
        chk("t5_no_done", dc, -1);
        run_req(2'd1, 6'd3, 7'd3, 4'b1111, 0, 0, fs, fv, dc);
        chk("t5_fresh_done", dc, 5);

        // Full bank from base 10: 64 rows, one per cycle.
        run_req(2'd0, 6'd10, 7'd64, 4'b1111, 0, 0, fs, fv, dc);
        chk("t6_first_valid", fv, 2);
        chk("t6_done_cycle", dc, 66);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/read_out.md
Name: read_out

Overview:
- Reader counterpart of the output-SRAM write path: drains result rows from output SRAM bank a, b or c.
- Issues sequential row addresses and captures the 1-cycle-latency read data.
- Undoes the writer's lane reversal: SRAM lane MAX_INDEX-i becomes output lane i.
- Streams rows to the host/DMA side over a valid/ready handshake, with back-pressure.

Parameters:
ARRAY_SIZE, 32, lanes per SRAM word
OUTPUT_DATA_WIDTH, 16, bits per lane
ADDR_WIDTH, 6, SRAM row address width (64 rows per bank)

Ports:
clk  in  1  clock
srst  in  1  synchronous reset, active-high
start  in  1  one-cycle request pulse; accepted only in IDLE
bank_sel  in  2  0=a, 1=b, 2=c; 3 is illegal
base_addr  in  ADDR_WIDTH  first row to read
num_rows  in  ADDR_WIDTH+1  rows to read, 1..64
sram_read_enable_a0  out  1  active-low read strobe, bank a
sram_raddr_a  out  ADDR_WIDTH  read address, bank a
sram_rdata_a  in  ARRAY_SIZE*OUTPUT_DATA_WIDTH  bank a data, valid 1 cycle after strobe
(same three ports for banks b and c: sram_read_enable_b0/_c0, sram_raddr_b/_c, sram_rdata_b/_c)
out_valid  out  1  out_data holds a row
out_ready  in  1  consumer accepts the row when out_valid & out_ready
out_data  out  ARRAY_SIZE*OUTPUT_DATA_WIDTH  row data, lane i at bits [i*W +: W]
out_last  out  1  marks the final row of the request
busy  out  1  high from start acceptance until the last row is handed off
done  out  1  one-cycle pulse the cycle after the last handshake

Behaviour:
- Reset values: all read strobes 1 (idle), all raddr 0, out_valid 0, out_data 0, out_last 0, busy 0, done 0. FSM goes to IDLE; FIFO and counters are cleared.
- srst wins over every other input, including a simultaneous start.
- Reset mid-request abandons the request: no done pulse, and read data in flight is discarded.
- FSM states and transitions:
  - IDLE: start with bank_sel != 3 and num_rows != 0 -> latch bank, addr = base_addr, issue_cnt = num_rows, busy = 1 -> READ.
  - IDLE: start with bank_sel == 3 or num_rows == 0 -> ignored; no busy, no done.
  - READ: issue one read when credit is available, i.e. fifo_count + inflight < 2.
    - Issuing a read: selected strobe = 0, raddr = addr, addr = addr + 1 (wraps 63 -> 0), issue_cnt decrements.
    - Strobes of unselected banks stay 1.
    - When issue_cnt reaches 0 -> DRAIN.
  - DRAIN: the final out handshake pulses done next cycle, clears busy -> IDLE.
- Strobe and address are registered outputs. The data-capture flag (inflight) follows a strobe by exactly 1 cycle.
- Captured word is lane-reversed, then pushed into a 2-entry FIFO. Credit accounting guarantees the FIFO never overflows.
- out_data comes directly from the FIFO head. out_valid = FIFO not empty.
- out_valid, once high, must not drop and out_data must not change until the handshake completes.
- out_last is high with the head entry when that entry is row num_rows-1 of the request. An output-side counter tracks this.
- Throughput: 1 row/cycle with out_ready held high. First out_valid arrives 2 cycles after start acceptance (issue cycle + SRAM latency).
- start during busy is ignored; latched parameters stay unchanged.
- num_rows = 64 reads all rows, wrapping from base_addr back to base_addr-1.

Decomposition:
- Package read_out_pkg holds:
  - bank encodings BANK_A=0, BANK_B=1, BANK_C=2
  - state enum IDLE/READ/DRAIN
  - ADDR_WIDTH
- Sub-module read_skid_fifo: 2-entry, parameterised width, push/pop/count, synchronous active-high reset.

Test Plan:
1. Bank a, base 0, 4 rows, out_ready=1 -> strobe_a low for cycles 1-4 at addr 0..3. out_valid cycles 2-5 with lanes reversed. out_last on row 3, done cycle 6, strobes b/c stay 1.
2. Bank c, base 62, 3 rows -> raddr_c sequence 62, 63, 0. out_last on the row read from addr 0.
3. Bank b, 8 rows, out_ready toggled 1,0,0,1,... -> no row dropped or duplicated, out_data stable while stalled, at most 2 reads outstanding beyond consumed rows.
4. start during busy with different bank/base -> ignored; original 8-row sequence completes unchanged; start with bank_sel=3 or num_rows=0 -> no busy, no done.
5. srst asserted in READ after 2 of 6 rows -> next cycle all strobes 1, out_valid 0, busy 0, no done; a fresh start then runs normally.
6. num_rows=64 from base 10, out_ready=1 -> 64 consecutive rows, addresses wrap 63 -> 0 -> 9, throughput 1 row/cycle after the first.
